// File: rtl/collision_scorer.sv
// rtl/collision_scorer.sv - runner/obstacle collision detector with BCD score and high score
module collision_scorer #(
  parameter int MAX_HEIGHT  = 19,
  parameter int GRACE_TICKS = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        move,
  input  logic        tick,
  input  logic [4:0]  runner_height,
  input  logic [1:0]  obstacle_col,
  output logic        stop_req,
  output logic        hit_pulse,
  output logic [15:0] score_bcd,
  output logic [15:0] high_bcd,
  output logic [1:0]  state_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HIT  = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  localparam int GW = (GRACE_TICKS < 1) ? 1 : $clog2(GRACE_TICKS + 1);

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] grace_q, grace_d;
  logic [1:0]    prev_q, prev_d;
  logic [15:0]   score_q, score_d;
  logic [15:0]   high_q, high_d;

  logic [4:0] h_norm;
  logic       collide;
  logic       clear_evt;

  // Digit-serial BCD increment, holding at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (v[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Heights above the legal maximum come from datapath underflow and mean ground level.
  assign h_norm    = (runner_height > 5'(MAX_HEIGHT)) ? 5'd0 : runner_height;
  assign collide   = (obstacle_col != 2'd0) && (h_norm <= {3'b000, obstacle_col})
                     && (grace_q == '0);
  assign clear_evt = (prev_q != 2'd0) && (obstacle_col == 2'd0) && !collide;

  always_comb begin
    state_d = state_q;
    grace_d = grace_q;
    prev_d  = prev_q;
    score_d = score_q;
    high_d  = high_q;
    case (state_q)
      ST_IDLE: begin
        score_d = 16'h0000;
        if (!start && move) begin
          state_d = ST_RUN;
          grace_d = GW'(GRACE_TICKS);
          prev_d  = 2'd0;
        end
      end
      ST_RUN: begin
        if (start) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          prev_d = obstacle_col;
          if (grace_q != '0) begin
            grace_d = grace_q - GW'(1);
          end
          if (collide) begin
            state_d = ST_HIT;
          end else if (clear_evt) begin
            score_d = bcd_inc(score_q);
          end
        end
      end
      ST_HIT: begin
        if (score_q > high_q) begin
          high_d = score_q;
        end
        state_d = start ? ST_IDLE : ST_OVER;
      end
      ST_OVER: begin
        if (start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grace_q <= '0;
      prev_q  <= 2'd0;
      score_q <= 16'h0000;
      high_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      grace_q <= grace_d;
      prev_q  <= prev_d;
      score_q <= score_d;
      high_q  <= high_d;
    end
  end

  assign hit_pulse = (state_q == ST_HIT);
  assign stop_req  = (state_q == ST_HIT) || (state_q == ST_OVER);
  assign score_bcd = score_q;
  assign high_bcd  = high_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_collision_scorer.sv
// tb/tb_collision_scorer.sv - directed self-checking bench for collision_scorer
module tb_collision_scorer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        move;
  logic        tick;
  logic [4:0]  runner_height;
  logic [1:0]  obstacle_col;
  logic        stop_req;
  logic        hit_pulse;
  logic [15:0] score_bcd;
  logic [15:0] high_bcd;
  logic [1:0]  state_out;

  int vectors     = 0;
  int miscompares = 0;

  collision_scorer #(.MAX_HEIGHT(19), .GRACE_TICKS(4)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .move          (move),
    .tick          (tick),
    .runner_height (runner_height),
    .obstacle_col  (obstacle_col),
    .stop_req      (stop_req),
    .hit_pulse     (hit_pulse),
    .score_bcd     (score_bcd),
    .high_bcd      (high_bcd),
    .state_out     (state_out)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic status(input string tag, input logic [1:0] st, input logic hit, input logic stp);
    chk({tag, ".state"}, 16'(state_out), 16'(st));
    chk({tag, ".hit"},   16'(hit_pulse), 16'(hit));
    chk({tag, ".stop"},  16'(stop_req),  16'(stp));
  endtask

  task automatic do_tick(input logic [4:0] h, input logic [1:0] o);
    runner_height = h;
    obstacle_col  = o;
    tick          = 1'b1;
    cyc();
    tick          = 1'b0;
  endtask

  task automatic enter_run();
    start = 1'b1;
    cyc();
    start = 1'b0;
    move  = 1'b1;
    cyc();
    move  = 1'b0;
  endtask

  task automatic grace_idle();
    repeat (4) do_tick(5'd10, 2'd0);
  endtask

  task automatic clear_n(input int n);
    for (int i = 0; i < n; i++) begin
      do_tick(5'd10, 2'd2);
      do_tick(5'd10, 2'd0);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; move = 1'b0; tick = 1'b0;
    runner_height = 5'd0; obstacle_col = 2'd0;
    repeat (2) cyc();
    status("reset", 2'd0, 1'b0, 1'b0);
    chk("reset.score", score_bcd, 16'h0000);
    chk("reset.high",  high_bcd,  16'h0000);
    resetn = 1'b1;
    cyc();

    // Grace window: four ignored ticks, fifth collides.
    enter_run();
    chk("grace.enter", 16'(state_out), 16'd1);
    for (int i = 1; i <= 4; i++) begin
      do_tick(5'd0, 2'd3);
      status($sformatf("grace.t%0d", i), 2'd1, 1'b0, 1'b0);
    end
    do_tick(5'd0, 2'd3);
    status("grace.hit", 2'd2, 1'b1, 1'b1);
    cyc();
    status("grace.over", 2'd3, 1'b0, 1'b1);
    chk("grace.high", high_bcd, 16'h0000);

    // Scoring: 2,2,0 gives one clear; ten of them give 0x0010.
    enter_run();
    chk("score.restart_stop", 16'(stop_req), 16'd0);
    grace_idle();
    do_tick(5'd10, 2'd2); do_tick(5'd10, 2'd2); do_tick(5'd10, 2'd0);
    chk("score.one", score_bcd, 16'h0001);
    for (int i = 0; i < 9; i++) begin
      do_tick(5'd10, 2'd2); do_tick(5'd10, 2'd2); do_tick(5'd10, 2'd0);
    end
    chk("score.ten", score_bcd, 16'h0010);

    // Wrapped height 31 counts as ground and collides.
    do_tick(5'd31, 2'd1);
    status("wrap.hit", 2'd2, 1'b1, 1'b1);
    cyc();
    chk("wrap.high", high_bcd, 16'h0010);
    chk("wrap.state", 16'(state_out), 16'd3);

    enter_run();
    chk("wrap.score_cleared", score_bcd, 16'h0000);
    chk("wrap.high_kept", high_bcd, 16'h0010);
    grace_idle();
    do_tick(5'd2, 2'd1);
    status("wrap.h2_nohit", 2'd1, 1'b0, 1'b0);
    do_tick(5'd19, 2'd3);
    status("max.h19_nohit", 2'd1, 1'b0, 1'b0);
    do_tick(5'd10, 2'd0);
    chk("wrap.clear", score_bcd, 16'h0001);

    // Saturation at 9999.
    clear_n(9998);
    chk("sat.9999", score_bcd, 16'h9999);
    clear_n(1);
    chk("sat.hold", score_bcd, 16'h9999);
    do_tick(5'd20, 2'd1);
    status("sat.hit_h20", 2'd2, 1'b1, 1'b1);
    cyc();
    chk("sat.high", high_bcd, 16'h9999);
    do_tick(5'd10, 2'd0);
    chk("over.tick_score", score_bcd, 16'h9999);
    chk("over.tick_state", 16'(state_out), 16'd3);

    enter_run();
    chk("run2.score", score_bcd, 16'h0000);
    chk("run2.high", high_bcd, 16'h9999);
    grace_idle();
    clear_n(1);
    do_tick(5'd3, 2'd3);
    status("run2.hit_eq", 2'd2, 1'b1, 1'b1);
    cyc();
    chk("run2.high_kept", high_bcd, 16'h9999);
    chk("run2.score_frozen", score_bcd, 16'h0001);

    // start beats a colliding tick.
    enter_run();
    grace_idle();
    start = 1'b1;
    do_tick(5'd0, 2'd3);
    start = 1'b0;
    status("prio.start", 2'd0, 1'b0, 1'b0);
    move = 1'b1;
    cyc();
    move = 1'b0;
    grace_idle();
    do_tick(5'd10, 2'd2);
    do_tick(5'd0, 2'd0);
    status("prio.clear_nohit", 2'd1, 1'b0, 1'b0);
    chk("prio.clear_score", score_bcd, 16'h0001);
    do_tick(5'd10, 2'd2);
    do_tick(5'd1, 2'd3);
    status("prio.hit", 2'd2, 1'b1, 1'b1);
    chk("prio.hit_score", score_bcd, 16'h0001);
    cyc();

    // Reset from OVER with a nonzero high score.
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    chk("rst1.high", high_bcd, 16'h0000);
    enter_run();
    grace_idle();
    clear_n(42);
    chk("rst.score42", score_bcd, 16'h0042);
    do_tick(5'd0, 2'd1);
    cyc();
    status("rst.over", 2'd3, 1'b0, 1'b1);
    chk("rst.high42", high_bcd, 16'h0042);
    resetn = 1'b0;
    cyc();
    status("rst.mid", 2'd0, 1'b0, 1'b0);
    chk("rst.mid_score", score_bcd, 16'h0000);
    chk("rst.mid_high", high_bcd, 16'h0000);
    resetn = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
